// File: rtl/tacho_pkg.sv
// Shared types, constants and helpers for the tachometer family (hall_pulse_gen).
package tacho_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned BOUNCE_LEN            = 4;
    localparam int unsigned DEFAULT_WINDOW_CYCLES = 100_000_000;

    // Highest rate whose pulse spacing still fits the pulse plus an equal low time and any preamble.
    function automatic int unsigned max_rate(input int unsigned window_cycles,
                                             input int unsigned pulse_w,
                                             input int unsigned gap);
        return window_cycles / (2 * pulse_w + gap);
    endfunction

endpackage

// File: rtl/hall_pulse_gen_if.sv
// Rate request handshake between a rate source (master) and hall_pulse_gen (slave).
interface hall_pulse_gen_if #(
    parameter int unsigned RATE_W = 16
);
    logic [RATE_W-1:0] rate_i;
    logic              rate_valid;
    logic              rate_ready;

    modport master (output rate_i, output rate_valid, input rate_ready);
    modport slave  (input rate_i, input rate_valid, output rate_ready);
endinterface

// File: rtl/hall_pulse_gen_pulse_shaper.sv
// Turns a one-cycle event strobe into a registered Hall pulse one cycle later.
// With HALL_BOUNCE_EN defined, each pulse is preceded by a 1,0,1,0 bounce preamble.
module pulse_shaper
    import tacho_pkg::*;
#(
    parameter int unsigned PULSE_W = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic fire,
    output logic pulse_out,
    output logic busy
);

`ifdef HALL_BOUNCE_EN
    localparam int unsigned SEQ_LEN = BOUNCE_LEN + PULSE_W;
`else
    localparam int unsigned SEQ_LEN = PULSE_W;
`endif
    localparam int unsigned CNT_W = $clog2(SEQ_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SEQ_LEN - 1);

    logic [CNT_W-1:0] cnt;
    logic             level_c;

`ifdef HALL_BOUNCE_EN
    logic [CNT_W-1:0] idx_c;

    // Level of the next sequence slot: alternating preamble, then solid high.
    always_comb begin
        idx_c   = CNT_W'(SEQ_LEN) - cnt;
        level_c = (idx_c < CNT_W'(BOUNCE_LEN)) ? ~idx_c[0] : 1'b1;
    end
`else
    assign level_c = 1'b1;
`endif

    // Remaining-slot down-counter and registered pulse level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            busy <= fire || (cnt != '0);
            if (fire) begin
                cnt       <= CNT_LOAD;
                pulse_out <= 1'b1;
            end else if (cnt != '0) begin
                cnt       <= cnt - CNT_W'(1);
                pulse_out <= level_c;
            end else begin
                pulse_out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hall_pulse_gen.sv
// Hall-sensor emulator: emits exactly `active` evenly spaced pulses per measurement window.
// Optional contact-bounce preamble enabled by defining HALL_BOUNCE_EN.
module hall_pulse_gen
    import tacho_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
    parameter int unsigned PULSE_W       = 1,
    parameter int unsigned RATE_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    hall_pulse_gen_if.slave   rate_bus,
    output logic              pulse_out,
    output logic              window_start,
    output logic [RATE_W-1:0] sent_count,
    output logic              sent_valid,
    output logic              rate_clamped,
    output logic              busy
);

`ifdef HALL_BOUNCE_EN
    localparam int unsigned GAP = BOUNCE_LEN;
`else
    localparam int unsigned GAP = 0;
`endif
    localparam int unsigned MAX_RATE = max_rate(WINDOW_CYCLES, PULSE_W, GAP);
    localparam int unsigned WC_W     = $clog2(WINDOW_CYCLES);
    localparam int unsigned ACC_W    = $clog2(2 * WINDOW_CYCLES);

    localparam logic [WC_W-1:0]  WC_LAST     = WC_W'(WINDOW_CYCLES - 1);
    localparam logic [ACC_W-1:0] ACC_WIN     = ACC_W'(WINDOW_CYCLES);
    localparam logic [ACC_W-1:0] ACC_PRELOAD = ACC_W'(WINDOW_CYCLES - 1);

    state_t            state, state_n;
    logic [WC_W-1:0]   wc;
    logic [ACC_W-1:0]  acc;
    logic [RATE_W-1:0] shadow;
    logic [RATE_W-1:0] active;
    logic [RATE_W-1:0] win_cnt;

    logic              running_c;
    logic              wc_zero_c;
    logic              last_c;
    logic [RATE_W-1:0] act_c;
    logic [ACC_W-1:0]  sum_c;
    logic              ev_c;
    logic              shaper_busy;

    // Window position decode and accumulator step; cycle 0 uses the preload and the fresh shadow.
    always_comb begin
        running_c = (state != IDLE);
        wc_zero_c = (wc == '0);
        last_c    = (wc == WC_LAST);
        act_c     = wc_zero_c ? shadow : active;
        sum_c     = (wc_zero_c ? ACC_PRELOAD : acc) + ACC_W'(act_c);
        ev_c      = running_c && (sum_c >= ACC_WIN);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state: DRAIN finishes the current window unless en comes back.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (en) state_n = RUN;
            RUN:     if (!en) state_n = last_c ? IDLE : DRAIN;
            DRAIN: begin
                if (en)          state_n = RUN;
                else if (last_c) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Rate handshake: clamp to the non-overlap limit; shadow only reaches active at cycle 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rate_bus.rate_ready <= 1'b0;
            shadow              <= '0;
            rate_clamped        <= 1'b0;
        end else begin
            rate_bus.rate_ready <= 1'b1;
            if (rate_bus.rate_valid && rate_bus.rate_ready) begin
                if (32'(rate_bus.rate_i) > MAX_RATE) begin
                    shadow       <= RATE_W'(MAX_RATE);
                    rate_clamped <= 1'b1;
                end else begin
                    shadow <= rate_bus.rate_i;
                end
            end
        end
    end

    // Window counter, accumulator, per-window pulse count and status strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wc           <= '0;
            acc          <= '0;
            active       <= '0;
            win_cnt      <= '0;
            sent_count   <= '0;
            sent_valid   <= 1'b0;
            window_start <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sent_valid   <= 1'b0;
            window_start <= (state_n != IDLE) && (!running_c || last_c);
            busy         <= (state_n != IDLE) || shaper_busy;
            if (running_c) begin
                wc      <= last_c ? '0 : wc + WC_W'(1);
                acc     <= ev_c ? (sum_c - ACC_WIN) : sum_c;
                win_cnt <= (wc_zero_c ? '0 : win_cnt) + RATE_W'(ev_c);
                if (wc_zero_c) active <= shadow;
                if (last_c) begin
                    sent_count <= win_cnt + RATE_W'(ev_c);
                    sent_valid <= 1'b1;
                end
            end
        end
    end

    pulse_shaper #(
        .PULSE_W (PULSE_W)
    ) u_shaper (
        .clk       (clk),
        .rst       (rst),
        .fire      (ev_c),
        .pulse_out (pulse_out),
        .busy      (shaper_busy)
    );

endmodule

// File: tb/tb_hall_pulse_gen.sv
// Self-checking bench for hall_pulse_gen with a short window and randomized rates.
module tb_hall_pulse_gen;

    localparam int W  = 100;
    localparam int PW = 1;
    localparam int RW = 16;
`ifdef HALL_BOUNCE_EN
    localparam int GAPT = 4;
`else
    localparam int GAPT = 0;
`endif
    localparam int MAXR = W / (2 * PW + GAPT);
    localparam int SEQ  = PW + GAPT;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          pulse_out;
    logic          window_start;
    logic [RW-1:0] sent_count;
    logic          sent_valid;
    logic          rate_clamped;
    logic          busy;

    int checks    = 0;
    int failures  = 0;
    int shadow_m  = 0;
    bit clamp_exp = 1'b0;

    hall_pulse_gen_if #(.RATE_W(RW)) rbus ();

    hall_pulse_gen #(
        .WINDOW_CYCLES (W),
        .PULSE_W       (PW),
        .RATE_W        (RW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .rate_bus     (rbus),
        .pulse_out    (pulse_out),
        .window_start (window_start),
        .sent_count   (sent_count),
        .sent_valid   (sent_valid),
        .rate_clamped (rate_clamped),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Event k of a window fires when the running total r*(k+1) crosses a multiple of W.
    function automatic bit ev_at(input int r, input int e);
        return ((W - 1 + r * (e + 1)) / W) > ((W - 1 + r * e) / W);
    endfunction

    function automatic bit seq_level(input int i);
        return (i < GAPT) ? (i % 2 == 0) : 1'b1;
    endfunction

    // Expected pulse_out in window cycle k for rate r.
    function automatic bit model_level(input int r, input int k);
        for (int e = 0; e < k; e++)
            if (ev_at(r, e) && (k - e - 1) < SEQ) return seq_level(k - e - 1);
        return 1'b0;
    endfunction

    task automatic note_rate(input int r);
        shadow_m  = (r > MAXR) ? MAXR : r;
        clamp_exp = clamp_exp | (r > MAXR);
    endtask

    task automatic send_rate(input int r);
        rbus.rate_i     = RW'(r);
        rbus.rate_valid = 1'b1;
        tick();
        rbus.rate_valid = 1'b0;
        note_rate(r);
    endtask

    // Follows one full window from its cycle 0, optionally changing rate or en mid-window.
    task automatic check_window(input int chg_at, input int chg_rate,
                                input int drop_at, input int rise_at);
        int      waited = 0;
        int      r;
        int      bad_k = -1;
        logic    bad_p = 1'b0;
        logic    bad_ws = 1'b0;
        logic    bad_b = 1'b0;
        logic    bad_sv = 1'b0;
        bit      exp_p;
        logic [RW-1:0] exp_cnt;
        while (window_start !== 1'b1 && waited < 3 * W) begin
            tick();
            waited++;
        end
        checks++;
        if (window_start !== 1'b1) begin
            failures++;
            $display("FAIL window_start_timeout: window_start=%b after %0d cycles, required 1", window_start, waited);
            return;
        end
        r = shadow_m;
        for (int k = 0; k < W; k++) begin
            exp_p = model_level(r, k);
            if (bad_k < 0 && (pulse_out !== exp_p || window_start !== (k == 0) ||
                              busy !== 1'b1 || (k > 0 && sent_valid !== 1'b0))) begin
                bad_k = k; bad_p = pulse_out; bad_ws = window_start; bad_b = busy; bad_sv = sent_valid;
            end
            if (k == chg_at) begin
                rbus.rate_i     = RW'(chg_rate);
                rbus.rate_valid = 1'b1;
                note_rate(chg_rate);
            end else begin
                rbus.rate_valid = 1'b0;
            end
            if (k == drop_at) en = 1'b0;
            if (k == rise_at) en = 1'b1;
            tick();
        end
        rbus.rate_valid = 1'b0;
        checks++;
        if (bad_k >= 0) begin
            failures++;
            $display("FAIL window_pattern rate=%0d wc=%0d: pulse=%b ws=%b busy=%b sv=%b, required pulse=%b ws=%b busy=1 sv=%b",
                     r, bad_k, bad_p, bad_ws, bad_b, bad_sv, model_level(r, bad_k), (bad_k == 0), 1'b0);
        end
        exp_cnt = RW'(r);
        checks++;
        if (sent_valid !== 1'b1 || sent_count !== exp_cnt) begin
            failures++;
            $display("FAIL sent_count rate=%0d: sent_valid=%b sent_count=%0d, required 1 and %0d", r, sent_valid, sent_count, exp_cnt);
        end
        checks++;
        if (rate_clamped !== clamp_exp) begin
            failures++;
            $display("FAIL rate_clamped: got %b, required %b", rate_clamped, clamp_exp);
        end
    endtask

    // Checks the generator stays silent and idle for n cycles.
    task automatic expect_quiet(input string name, input int n);
        int bad_k = -1;
        for (int k = 0; k < n; k++) begin
            if (bad_k < 0 && (pulse_out !== 1'b0 || window_start !== 1'b0 ||
                              sent_valid !== 1'b0 || busy !== 1'b0)) bad_k = k;
            tick();
        end
        checks++;
        if (bad_k >= 0) begin
            failures++;
            $display("FAIL %s: activity at idle cycle %0d (pulse=%b ws=%b sv=%b busy=%b), required all 0",
                     name, bad_k, pulse_out, window_start, sent_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        rbus.rate_i = '0; rbus.rate_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if ({pulse_out, window_start, sent_count, sent_valid, rate_clamped, busy, rbus.rate_ready} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: pulse=%b ws=%b cnt=%0d sv=%b clamp=%b busy=%b ready=%b, required all 0",
                     pulse_out, window_start, sent_count, sent_valid, rate_clamped, busy, rbus.rate_ready);
        end
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (rbus.rate_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ready_after_reset: ready=%b busy=%b, required 1 and 0", rbus.rate_ready, busy);
        end
    endtask

    task automatic test_basic();
        send_rate(3);
        en = 1'b1;
        check_window(-1, 0, -1, -1);
    endtask

    task automatic test_rate_change();
        check_window(40, 5, -1, -1);
        check_window(-1, 0, -1, -1);
    endtask

    task automatic test_zero_rate();
        check_window(30, 0, -1, -1);
        check_window(-1, 0, -1, -1);
    endtask

    task automatic test_clamp();
        check_window(55, 80, -1, -1);
        check_window(-1, 0, -1, -1);
    endtask

    task automatic test_boundary_accept();
        check_window(0, 7, -1, -1);
        check_window(-1, 0, -1, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++)
            check_window(int'($urandom_range(W - 1, 0)), int'($urandom_range(90, 0)), -1, -1);
        check_window(-1, 0, -1, -1);
    endtask

    task automatic test_drain();
        check_window(20, 3, -1, -1);
        check_window(-1, 0, 10, -1);
        tick();
        expect_quiet("drain_idle", 2 * W);
    endtask

    task automatic test_drain_resume();
        en = 1'b1;
        check_window(-1, 0, 10, 20);
        checks++;
        if (window_start !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL drain_resume_gap: ws=%b busy=%b, required 1 and 1", window_start, busy);
        end
        check_window(-1, 0, -1, -1);
    endtask

    task automatic test_reset_mid();
        check_window(10, 50, -1, -1);
        repeat (50) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({pulse_out, window_start, sent_count, sent_valid, rate_clamped, busy, rbus.rate_ready} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs: pulse=%b ws=%b cnt=%0d sv=%b clamp=%b busy=%b ready=%b, required all 0",
                     pulse_out, window_start, sent_count, sent_valid, rate_clamped, busy, rbus.rate_ready);
        end
        en = 1'b0;
        shadow_m = 0;
        clamp_exp = 1'b0;
        tick();
        rst = 1'b0;
        expect_quiet("reset_mid_quiet", W + 20);
    endtask

    task automatic test_recover();
        send_rate(int'($urandom_range(MAXR, 1)));
        en = 1'b1;
        check_window(-1, 0, -1, -1);
        check_window(-1, 0, -1, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rate_change();
        test_zero_rate();
        test_clamp();
        test_boundary_accept();
        test_random();
        test_drain();
        test_drain_resume();
        test_reset_mid();
        test_recover();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hall_pulse_gen.md
Name: hall_pulse_gen

Overview:
Synthesizable Hall-sensor emulator. It is the transmit side of the tachometer's pulse_in interface.
- Generates exactly N evenly spaced pulses per measurement window, where N is a programmed rate.
- Drives pulse_in of the tachometer for on-board self-test, or for bench closed-loop checks of count_out, led and buzzer.
- Uses the same window length as the tachometer's tick period.

Parameters:
WINDOW_CYCLES, 100_000_000, clock cycles per measurement window (must match the tachometer tick period).
PULSE_W, 1, high time of each pulse in clock cycles (>=1).
RATE_W, 16, width of the rate and count fields.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  run request.
rate_i  input  RATE_W  requested pulses per window.
rate_valid  input  1  rate_i offered.
rate_ready  output  1  rate accepted when rate_valid & rate_ready.
pulse_out  output  1  emulated Hall output; connects to tachometer pulse_in.
window_start  output  1  one-cycle strobe on window cycle 0.
sent_count  output  RATE_W  pulses emitted in the last completed window.
sent_valid  output  1  one-cycle strobe when sent_count updates.
rate_clamped  output  1  sticky; set when an accepted rate exceeded MAX_RATE.
busy  output  1  state != IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; shadow rate, active rate, window counter and accumulator all 0; rate_clamped cleared.
- Reset mid-window aborts immediately. pulse_out drops in the same cycle the reset is sampled, and no sent_valid is issued.
- MAX_RATE = WINDOW_CYCLES / (2*PULSE_W + G), integer division. G = 0, or 4 with HALL_BOUNCE_EN.
- Rate handshake:
  - rate_ready = 1 whenever not in reset.
  - On accept, shadow <= min(rate_i, MAX_RATE). rate_clamped is set if rate_i > MAX_RATE.
  - Shadow is copied to the active rate only at a window boundary (cycle 0 of a window). The active rate never changes mid-window.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: when en=1, go to RUN. Next cycle is window cycle 0.
  - RUN: window counter wc runs 0..WINDOW_CYCLES-1 and wraps. If en=0 is seen, go to DRAIN.
  - DRAIN: completes the current window, including the final sent_count/sent_valid, then goes to IDLE. en reasserted during DRAIN returns to RUN with no gap.
- At wc = 0:
  - window_start = 1.
  - active <= shadow.
  - acc <= WINDOW_CYCLES-1.
  - Window pulse counter cleared.
- Pulse scheduling, each RUN/DRAIN cycle:
  - Let s = acc + active.
  - If s >= WINDOW_CYCLES: event fires and acc <= s - WINDOW_CYCLES. Otherwise acc <= s.
  - acc width is clog2(2*WINDOW_CYCLES).
  - Result: exactly `active` events per window. The first event is at wc = 0; spacing is floor or ceil of WINDOW_CYCLES/active.
  - The clamp guarantees spacing >= pulse length, so pulses never overlap and never cross the window end.
- Event output: pulse_out is registered high for PULSE_W cycles starting the cycle after the event (1-cycle latency). The window pulse counter increments on each event.
- At wc = WINDOW_CYCLES-1: sent_count <= window counter including that cycle's event; sent_valid = 1 on the following cycle.
- active = 0: pulse_out stays 0, and sent_count = 0 is reported each window.
- A rate accept and a window boundary in the same cycle: the new value goes to shadow. The boundary copies the old shadow.

Optional Feature:
HALL_BOUNCE_EN
- Defined: each pulse is preceded by a 4-cycle contact-bounce preamble 1,0,1,0, then PULSE_W cycles high. This exercises the receiver's debounce.
  - sent_count still counts one per pulse.
  - G = 4 in the MAX_RATE formula.
- Undefined: clean pulses only, G = 0, and no preamble logic is synthesized.

Decomposition:
- Shared package tacho_pkg holds:
  - State enum (IDLE, RUN, DRAIN).
  - Constants BOUNCE_LEN = 4 and DEFAULT_WINDOW_CYCLES.
  - Function computing MAX_RATE.
- One sub-module, pulse_shaper: takes an event strobe and produces pulse_out, including the optional bounce preamble. It has a down-counter and a busy output.

Test Plan:
1. WINDOW_CYCLES=100, PULSE_W=1, rate 3, en=1 -> pulse_out rises at wc 1, 34, 67; sent_count=3 with sent_valid after window end; rate_clamped=0.
2. rate 0 -> pulse_out stays 0 for a full window; sent_count=0.
3. rate 80 (MAX_RATE=50) -> shadow=50 and rate_clamped=1; next window gives 50 pulses, each 1-high/1-low; sent_count=50.
4. Rate change from 3 to 5 at wc=40 -> current window still gives 3; next window gives 5 pulses; window_start every 100 cycles.
5. en drops at wc=10 -> DRAIN finishes the window (sent_count=3), then IDLE with busy=0 and no further window_start. rst at wc=50 of a new run -> all outputs 0 on the next cycle and no sent_valid.
6. With HALL_BOUNCE_EN, rate 3 -> each pulse shows the 1,0,1,0,1 sequence; tachometer loopback reads count_out=3 only when its debounce is enabled; sent_count=3.
